imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock, all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: single-cycle load request.
REQ-004 SHALL have port word_count, input, 7 bits: number of 32-bit words to load; legal range 1..64; sampled on accepted start.
REQ-005 SHALL have port byte_valid, input, 1 bit: byte_data holds a valid byte.
REQ-006 SHALL have port byte_data, input, 8 bits: program byte stream.
REQ-007 SHALL have port byte_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-008 SHALL have port mem_we, output, 1 bit: instruction-memory write strobe.
REQ-009 SHALL have port mem_waddr, output, 14 bits: word address, same indexing as the fetch stage's PC[15:2].
REQ-010 SHALL have port mem_wdata, output, 32 bits: instruction word.
REQ-011 SHALL have port cpu_hold, output, 1 bit: holds the fetch stage and PC in reset while high.
REQ-012 SHALL have port done, output, 1 bit: image loaded and checksum passed.
REQ-013 SHALL have port error, output, 1 bit: load failed.

Function
REQ-014 SHALL implement the states IDLE, RECV, CHECK, DONE and ERR.
REQ-015 SHALL complete a byte transfer only in a cycle with byte_valid=1 and byte_ready=1; byte_ready=1 in RECV and CHECK only.
REQ-016 SHALL, in IDLE with start=1, go to RECV when word_count is in 1..64, else go to ERR; clear the address, byte index and checksum on entry to RECV.
REQ-017 SHALL pack bytes big-endian: 1st accepted byte to [31:24], 4th to [7:0].
REQ-018 SHALL assert mem_we for exactly one cycle, the cycle after the 4th byte of a word is accepted, with registered mem_waddr/mem_wdata stable in that cycle.
REQ-019 SHALL write words to mem_waddr 0,1,...,word_count-1 in order; mem_waddr[13:6] SHALL always be 0.
REQ-020 SHALL let byte acceptance continue in the mem_we cycle without a lost or duplicated byte.
REQ-021 SHALL keep checksum = XOR of all accepted data bytes, 8 bits.
REQ-022 SHALL go to CHECK after the last word's 4th byte is accepted; in CHECK, the next accepted byte is compared with the checksum: match to DONE, mismatch to ERR.
REQ-023 SHALL drive done=1 only in DONE and error=1 only in ERR.
REQ-024 SHALL drive cpu_hold=0 only in DONE and cpu_hold=1 in every other state.
REQ-025 SHALL re-arm on start from DONE or ERR with the same rules as IDLE, which makes cpu_hold rise the next cycle.
REQ-026 SHALL ignore start in RECV and CHECK.
REQ-027 SHALL tolerate byte_valid gaps of any length with no timeout; state is held.

Reset
REQ-028 SHALL, on reset, enter IDLE immediately from any state, including mid-word, and discard partial word and checksum.
REQ-029 SHALL reset outputs to: byte_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_hold=1, done=0, error=0.

Structure
REQ-030 SHALL put the state enum, IMEM_DEPTH=64 and address width 14 in a shared package.
REQ-031 SHALL implement byte-to-word packing, byte index and the valid-word pulse in a sub-module imem_word_packer; FSM, address counter and checksum stay in imem_loader.

Verification
REQ-032 SHALL cover: word_count=1, bytes 20,08,00,05, checksum 2D -> one mem_we, addr 0, data 0x20080005; done=1, cpu_hold=0.
REQ-033 SHALL cover: same bytes, checksum 00 -> no further writes; error=1, cpu_hold=1, done=0.
REQ-034 SHALL cover: word_count=64, byte k = k mod 256, correct checksum -> 64 writes to addr 0..63, addr 63 data 0xFCFDFEFF, then done=1.
REQ-035 SHALL cover: word_count=2 with random byte_valid gaps of 0..5 cycles -> same addr/data as back-to-back and exactly 2 mem_we pulses.
REQ-036 SHALL cover: reset after 2 bytes of word 0, then a full 1-word reload -> no mem_we before the reload; the reload writes the correct word.
REQ-037 SHALL cover: start with word_count=0, and with word_count=65 -> ERR next cycle, no mem_we, byte_ready=0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam int unsigned IMEM_DEPTH = 64;
    localparam int unsigned ADDR_W     = 14;

    function automatic logic count_ok(input logic [6:0] wc);
        return (wc != 7'd0) && (wc <= 7'(IMEM_DEPTH));
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream big-endian into 32-bit words; emits a one-cycle
// registered valid pulse with the completed word.
module imem_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  byte_idx_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx_q;
    logic [23:0] shift_q;
    logic        valid_q;
    logic [31:0] word_q;
    logic [31:0] word_d;

    assign word_d = {shift_q, byte_i};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            word_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            if (clear_i) begin
                idx_q   <= '0;
                shift_q <= '0;
            end else if (byte_en_i) begin
                shift_q <= word_d[23:0];
                idx_q   <= idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    valid_q <= 1'b1;
                    word_q  <= word_d;
                end
            end
        end
    end

    assign byte_idx_o   = idx_q;
    assign word_valid_o = valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a checksummed program image from a byte stream into instruction
// memory, holding the CPU until the image is verified.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [6:0]        word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    state_e            state_q, state_d;
    logic [6:0]        wc_q;
    logic [6:0]        word_cnt_q;
    logic [7:0]        csum_q;
    logic [ADDR_W-1:0] waddr_q;
    logic              byte_ready_q, cpu_hold_q, done_q, error_q;
    logic              accept, recv_byte, word_last, clear;
    logic [1:0]        byte_idx;

    assign accept    = byte_valid && byte_ready_q;
    assign recv_byte = accept && (state_q == ST_RECV);
    assign word_last = recv_byte && (byte_idx == 2'd3);
    assign clear     = start && count_ok(word_count) &&
                       ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR:
                if (start) state_d = count_ok(word_count) ? ST_RECV : ST_ERR;
            ST_RECV:
                if (word_last && ((word_cnt_q + 7'd1) == wc_q)) state_d = ST_CHECK;
            ST_CHECK:
                if (accept) state_d = (byte_data == csum_q) ? ST_DONE : ST_ERR;
            default:
                state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wc_q         <= '0;
            word_cnt_q   <= '0;
            csum_q       <= '0;
            waddr_q      <= '0;
            byte_ready_q <= 1'b0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= (state_d == ST_RECV) || (state_d == ST_CHECK);
            cpu_hold_q   <= (state_d != ST_DONE);
            done_q       <= (state_d == ST_DONE);
            error_q      <= (state_d == ST_ERR);
            if (clear) begin
                wc_q       <= word_count;
                word_cnt_q <= '0;
                csum_q     <= '0;
            end else if (recv_byte) begin
                csum_q <= csum_q ^ byte_data;
                if (word_last) begin
                    waddr_q    <= ADDR_W'(word_cnt_q[5:0]);
                    word_cnt_q <= word_cnt_q + 7'd1;
                end
            end
        end
    end

    imem_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (clear),
        .byte_en_i    (recv_byte),
        .byte_i       (byte_data),
        .byte_idx_o   (byte_idx),
        .word_valid_o (mem_we),
        .word_o       (mem_wdata)
    );

    assign byte_ready = byte_ready_q;
    assign mem_waddr  = waddr_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader against an image-level reference model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset, start, byte_valid;
    logic [6:0]  word_count;
    logic [7:0]  byte_data;
    logic        byte_ready, mem_we, cpu_hold, done, error;
    logic [13:0] mem_waddr;
    logic [31:0] mem_wdata;

    int total = 0;
    int bad   = 0;

    logic [13:0] cap_addr[$];
    logic [31:0] cap_data[$];
    logic [13:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  tx[$];

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            cap_addr.push_back(mem_waddr);
            cap_data.push_back(mem_wdata);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Image model: word i is bytes 4i..4i+3 MSB first at address i.
    task automatic build_model(input int wc);
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < wc; i++) begin
            exp_addr.push_back(14'(i));
            exp_data.push_back({tx[4*i], tx[4*i+1], tx[4*i+2], tx[4*i+3]});
        end
    endtask

    function automatic logic [7:0] model_csum();
        logic [7:0] c;
        c = 8'h00;
        foreach (tx[i]) c ^= tx[i];
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        guard = 0;
        for (int i = 0; i < gap; i++) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (byte_ready !== 1'b1) begin
            bad++;
            $display("FAIL byte_accept: byte_ready=%b required 1", byte_ready);
            byte_valid = 1'b0;
            return;
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic do_start(input logic [6:0] wc);
        start      = 1'b1;
        word_count = wc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; word_count = '0; byte_data = '0;
        repeat (2) @(negedge clk);
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL rst_byte_ready: got %b want 0", byte_ready); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        total++; if (mem_waddr !== 14'd0) begin bad++; $display("FAIL rst_waddr: got %h want 0", mem_waddr); end
        total++; if (mem_wdata !== 32'd0) begin bad++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); end
        total++; if (done !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL rst_done_err: got %b%b want 00", done, error); end
        reset = 1'b0;
        byte_valid = 1'b1;
        repeat (2) @(negedge clk);
        byte_valid = 1'b0;
        total++; if (byte_ready !== 1'b0 || cpu_hold !== 1'b1) begin bad++; $display("FAIL idle_state: ready=%b hold=%b want 0 1", byte_ready, cpu_hold); end
    endtask

    task automatic test_single();
        tx = '{8'h20, 8'h08, 8'h00, 8'h05};
        cap_addr.delete(); cap_data.delete();
        do_start(7'd1);
        foreach (tx[i]) send_byte(tx[i], 0);
        send_byte(8'h2D, 0);
        repeat (3) @(negedge clk);
        total++; if (cap_data.size() !== 1) begin bad++; $display("FAIL single_writes: got %0d want 1", cap_data.size()); end
        if (cap_data.size() >= 1) begin
            total++; if (cap_addr[0] !== 14'd0 || cap_data[0] !== 32'h20080005) begin bad++; $display("FAIL single_word: got %h:%h want 0000:20080005", cap_addr[0], cap_data[0]); end
        end
        total++; if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL single_done: done=%b hold=%b err=%b want 1 0 0", done, cpu_hold, error); end
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL done_ready: got %b want 0", byte_ready); end
    endtask

    task automatic test_bad_checksum();
        tx = '{8'h20, 8'h08, 8'h00, 8'h05};
        cap_addr.delete(); cap_data.delete();
        do_start(7'd1);
        total++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL rearm_hold: hold=%b done=%b want 1 0", cpu_hold, done); end
        foreach (tx[i]) send_byte(tx[i], 0);
        send_byte(8'h00, 0);
        repeat (3) @(negedge clk);
        total++; if (cap_data.size() !== 1) begin bad++; $display("FAIL badcs_writes: got %0d want 1", cap_data.size()); end
        total++; if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL badcs_state: err=%b hold=%b done=%b want 1 1 0", error, cpu_hold, done); end
    endtask

    task automatic test_full();
        tx.delete();
        for (int k = 0; k < 256; k++) tx.push_back(8'(k));
        build_model(64);
        cap_addr.delete(); cap_data.delete();
        do_start(7'd64);
        foreach (tx[i]) send_byte(tx[i], 0);
        send_byte(model_csum(), 0);
        repeat (3) @(negedge clk);
        total++; if (cap_data.size() !== 64) begin bad++; $display("FAIL full_writes: got %0d want 64", cap_data.size()); end
        foreach (exp_data[i]) if (i < cap_data.size()) begin
            total++; if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin bad++; $display("FAIL full_word%0d: got %h:%h want %h:%h", i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]); end
        end
        if (cap_data.size() == 64) begin
            total++; if (cap_addr[63] !== 14'd63 || cap_data[63] !== 32'hFCFDFEFF) begin bad++; $display("FAIL full_last: got %h:%h want 003f:fcfdfeff", cap_addr[63], cap_data[63]); end
        end
        total++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin bad++; $display("FAIL full_done: done=%b hold=%b want 1 0", done, cpu_hold); end
    endtask

    task automatic test_gaps();
        tx.delete();
        for (int k = 0; k < 8; k++) tx.push_back(8'($urandom));
        build_model(2);
        cap_addr.delete(); cap_data.delete();
        do_start(7'd2);
        foreach (tx[i]) begin
            send_byte(tx[i], $urandom_range(0, 5));
            if (i == 2) do_start(7'd0);
        end
        send_byte(model_csum(), $urandom_range(0, 5));
        repeat (3) @(negedge clk);
        total++; if (cap_data.size() !== 2) begin bad++; $display("FAIL gaps_writes: got %0d want 2", cap_data.size()); end
        foreach (exp_data[i]) if (i < cap_data.size()) begin
            total++; if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin bad++; $display("FAIL gaps_word%0d: got %h:%h want %h:%h", i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]); end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL gaps_done: got %b want 1", done); end
    endtask

    task automatic test_random();
        int wc;
        logic good;
        logic [7:0] cs;
        for (int it = 0; it < 6; it++) begin
            wc = $urandom_range(1, 6);
            good = 1'($urandom_range(0, 1));
            tx.delete();
            for (int k = 0; k < 4 * wc; k++) tx.push_back(8'($urandom));
            build_model(wc);
            cs = good ? model_csum() : model_csum() ^ 8'($urandom_range(1, 255));
            cap_addr.delete(); cap_data.delete();
            do_start(7'(wc));
            foreach (tx[i]) send_byte(tx[i], $urandom_range(0, 3));
            send_byte(cs, $urandom_range(0, 3));
            repeat (3) @(negedge clk);
            total++; if (cap_data.size() !== wc) begin bad++; $display("FAIL rand_writes: got %0d want %0d", cap_data.size(), wc); end
            foreach (exp_data[i]) if (i < cap_data.size()) begin
                total++; if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin bad++; $display("FAIL rand_word%0d: got %h:%h want %h:%h", i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]); end
            end
            total++; if (done !== good || error !== !good || cpu_hold !== !good) begin bad++; $display("FAIL rand_status: done=%b err=%b hold=%b good=%b", done, error, cpu_hold, good); end
        end
    endtask

    task automatic test_reset_midword();
        tx.delete();
        for (int k = 0; k < 4; k++) tx.push_back(8'($urandom));
        cap_addr.delete(); cap_data.delete();
        do_start(7'd1);
        send_byte(tx[0], 0);
        send_byte(tx[1], 0);
        reset = 1'b1;
        #1;
        total++; if (byte_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL async_reset: ready=%b hold=%b done=%b err=%b want 0 1 0 0", byte_ready, cpu_hold, done, error); end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (cap_data.size() !== 0) begin bad++; $display("FAIL midword_nowrite: got %0d want 0", cap_data.size()); end
        tx.delete();
        for (int k = 0; k < 4; k++) tx.push_back(8'($urandom));
        build_model(1);
        do_start(7'd1);
        foreach (tx[i]) send_byte(tx[i], 0);
        send_byte(model_csum(), 0);
        repeat (3) @(negedge clk);
        total++; if (cap_data.size() !== 1) begin bad++; $display("FAIL reload_writes: got %0d want 1", cap_data.size()); end
        if (cap_data.size() >= 1) begin
            total++; if (cap_addr[0] !== exp_addr[0] || cap_data[0] !== exp_data[0]) begin bad++; $display("FAIL reload_word: got %h:%h want %h:%h", cap_addr[0], cap_data[0], exp_addr[0], exp_data[0]); end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL reload_done: got %b want 1", done); end
    endtask

    task automatic test_illegal();
        logic [6:0] bad_wc[2];
        bad_wc[0] = 7'd0;
        bad_wc[1] = 7'd65;
        for (int n = 0; n < 2; n++) begin
            cap_addr.delete(); cap_data.delete();
            do_start(bad_wc[n]);
            total++; if (error !== 1'b1 || byte_ready !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b1) begin bad++; $display("FAIL illegal_wc%0d: err=%b ready=%b done=%b hold=%b want 1 0 0 1", bad_wc[n], error, byte_ready, done, cpu_hold); end
            byte_valid = 1'b1;
            byte_data  = 8'hA5;
            repeat (6) @(negedge clk);
            byte_valid = 1'b0;
            total++; if (cap_data.size() !== 0) begin bad++; $display("FAIL illegal_nowrite%0d: got %0d want 0", bad_wc[n], cap_data.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bad_checksum();
        test_full();
        test_gaps();
        test_random();
        test_reset_midword();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
